// File: rtl/pps_rst_tx.sv
// Transmit end of the PPS / PPS-reset link: 1 Hz tick, seconds count and a mid-second reset pulse.
// Optional external PPS phase alignment and lock detection is enabled by defining PPS_EXT_ALIGN_EN.
module pps_rst_tx #(
    parameter int CLK_HZ    = 300_000_000,
    parameter int PPS_WIDTH = 30_000_000,
    parameter int RST_WIDTH = 16,
    parameter int LOCK_TOL  = 8
) (
    input  logic        CLK_OUT,
    input  logic        RST_SW_t,
    input  logic        PPS_IN,
    input  logic        RST_REQ,
    output logic        RST_ACK,
    output logic        BUSY,
    output logic        PPS_OUT,
    output logic        PPS_RST_OUT,
    output logic [31:0] SEC_CNT,
    output logic        PPS_LOCKED
);

    localparam int CW = $clog2(CLK_HZ);
    localparam int RW = $clog2(RST_WIDTH + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2);
    localparam logic [CW-1:0] PPS_W_C  = CW'(PPS_WIDTH);
    localparam logic [RW-1:0] RST_W_C  = RW'(RST_WIDTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_SLOT = 3'd1;
    localparam logic [2:0] S_FIRE      = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    state;
    logic [RW-1:0] rst_cnt;
    logic          sec_clr;
    logic          pps_edge;

    // An external PPS edge restarts the second; otherwise the counter free-runs.
    always_comb begin
        cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        if (pps_edge) begin
            cnt_next = '0;
        end
    end

    assign sec_clr = (state == S_HOLD) && (cnt == PPS_W_C);

    always_ff @(posedge CLK_OUT or posedge RST_SW_t) begin
        if (RST_SW_t) begin
            cnt     <= '0;
            PPS_OUT <= 1'b0;
            SEC_CNT <= '0;
        end else begin
            cnt     <= cnt_next;
            PPS_OUT <= (cnt_next < PPS_W_C);
            if (sec_clr) begin
                SEC_CNT <= '0;
            end else if (cnt_next == '0) begin
                SEC_CNT <= SEC_CNT + 32'd1;
            end
        end
    end

    // The pulse is launched mid-second so every receiver releases on the same PPS falling edge.
    always_ff @(posedge CLK_OUT or posedge RST_SW_t) begin
        if (RST_SW_t) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            PPS_RST_OUT <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (RST_REQ) begin
                        state <= S_WAIT_SLOT;
                    end
                end
                S_WAIT_SLOT: begin
                    if (cnt == CNT_HALF) begin
                        state       <= S_FIRE;
                        rst_cnt     <= RW'(1);
                        PPS_RST_OUT <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (rst_cnt == RST_W_C) begin
                        state       <= S_HOLD;
                        PPS_RST_OUT <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_HOLD: begin
                    if (sec_clr) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!RST_REQ) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    PPS_RST_OUT <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY    = (state != S_IDLE);
    assign RST_ACK = (state == S_DONE);

`ifdef PPS_EXT_ALIGN_EN
    localparam logic [CW-1:0] TOL_LO = CW'(LOCK_TOL);
    localparam logic [CW-1:0] TOL_HI = CW'(CLK_HZ - 1 - LOCK_TOL);

    logic [2:0] pps_sync;
    logic       in_tol;
    logic [1:0] good_cnt;
    logic [1:0] miss_cnt;

    assign pps_edge = pps_sync[1] & ~pps_sync[2];
    // Edge arriving near the natural wrap, on either side of it, counts as in phase.
    assign in_tol   = (cnt >= TOL_HI) || (cnt < TOL_LO);

    always_ff @(posedge CLK_OUT or posedge RST_SW_t) begin
        if (RST_SW_t) begin
            pps_sync   <= '0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            PPS_LOCKED <= 1'b0;
        end else begin
            pps_sync <= {pps_sync[1:0], PPS_IN};
            if (pps_edge) begin
                miss_cnt <= '0;
                if (in_tol) begin
                    if (good_cnt != 2'd2) begin
                        good_cnt <= good_cnt + 2'd1;
                    end
                    if (good_cnt != 2'd0) begin
                        PPS_LOCKED <= 1'b1;
                    end
                end else begin
                    good_cnt   <= '0;
                    PPS_LOCKED <= 1'b0;
                end
            end else if (cnt == CNT_MAX) begin
                if (miss_cnt != 2'd2) begin
                    miss_cnt <= miss_cnt + 2'd1;
                end
                if (miss_cnt != 2'd0) begin
                    good_cnt   <= '0;
                    PPS_LOCKED <= 1'b0;
                end
            end
        end
    end
`else
    localparam int unused_lock_tol = LOCK_TOL;
    logic unused_pps_in;

    assign unused_pps_in = PPS_IN;
    assign pps_edge      = 1'b0;
    assign PPS_LOCKED    = 1'b0;
`endif

endmodule

// File: tb/tb_pps_rst_tx.sv
// Bench for pps_rst_tx: random request traffic checked against an event-time model of the link.
// Defining PPS_EXT_ALIGN_EN adds a directed external-alignment section.
module tb_pps_rst_tx;

    localparam int HZ  = 100;
    localparam int PW  = 10;
    localparam int RW  = 4;
    localparam int TOL = 2;

    logic        CLK_OUT  = 1'b0;
    logic        RST_SW_t = 1'b0;
    logic        PPS_IN   = 1'b0;
    logic        RST_REQ  = 1'b0;
    logic        RST_ACK;
    logic        BUSY;
    logic        PPS_OUT;
    logic        PPS_RST_OUT;
    logic [31:0] SEC_CNT;
    logic        PPS_LOCKED;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    bit model_on = 1'b0;
    bit act      = 1'b0;
    int tq, tw, th;
    int tend = -1;
    int clr_q[$];

    pps_rst_tx #(
        .CLK_HZ   (HZ),
        .PPS_WIDTH(PW),
        .RST_WIDTH(RW),
        .LOCK_TOL (TOL)
    ) dut (
        .CLK_OUT    (CLK_OUT),
        .RST_SW_t   (RST_SW_t),
        .PPS_IN     (PPS_IN),
        .RST_REQ    (RST_REQ),
        .RST_ACK    (RST_ACK),
        .BUSY       (BUSY),
        .PPS_OUT    (PPS_OUT),
        .PPS_RST_OUT(PPS_RST_OUT),
        .SEC_CNT    (SEC_CNT),
        .PPS_LOCKED (PPS_LOCKED)
    );

    always #5 CLK_OUT = ~CLK_OUT;

    // Bench-side cycle index: cycle t has the DUT counter at t mod HZ while free-running.
    always @(posedge CLK_OUT or posedge RST_SW_t) begin
        if (RST_SW_t) t <= 0;
        else          t <= t + 1;
    end

    function automatic int nextAt(int from, int phase);
        return from + ((phase - (from % HZ) + HZ) % HZ);
    endfunction

    function automatic int expSec(int tt);
        int base = 0;
        foreach (clr_q[i]) if (clr_q[i] <= tt) base = clr_q[i];
        return tt / HZ - base / HZ;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit live;
        if (!model_on) return;
        live = act && (tend < 0 || t <= tend);
        checkVal("pps_out", PPS_OUT, (t >= 1) && ((t % HZ) < PW));
        checkVal("sec_cnt", SEC_CNT, expSec(t));
        checkVal("busy", BUSY, live && (t >= tq + 1));
        checkVal("pps_rst", PPS_RST_OUT, act && (t >= tw + 1) && (t <= tw + RW));
        checkVal("rst_ack", RST_ACK, live && (t >= th + 1));
        checkVal("locked", PPS_LOCKED, 1'b0);
    endtask

    // A request is accepted when the link is idle; the pulse follows the next mid-second slot.
    task automatic updateModel(input bit req);
        if ((!act || (tend >= 0 && t > tend)) && req) begin
            act  = 1'b1;
            tq   = t;
            tw   = nextAt(t + 1, HZ / 2);
            th   = nextAt(tw + RW + 1, PW);
            tend = -1;
            clr_q.push_back(th + 1);
        end else if (act && tend < 0 && t >= th + 1 && !req) begin
            tend = t;
        end
    endtask

    task automatic applyStimulus(input bit req);
        @(negedge CLK_OUT);
        checkOutput();
        RST_REQ = req;
`ifndef PPS_EXT_ALIGN_EN
        PPS_IN = 1'($urandom_range(0, 1));
`endif
        updateModel(req);
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (!act || (tend >= 0 && t > tend)) break;
            applyStimulus(1'b0);
        end
        repeat (3) applyStimulus(1'b0);
    endtask

    task automatic doRequest(input int phase, input int hold);
        while (((t + 1) % HZ) != phase) applyStimulus(1'b0);
        repeat (hold) applyStimulus(1'b1);
        drain();
    endtask

    function automatic bit extPulse(int tt);
        int rises[7] = '{37, 137, 237, 500, 600, 700, 795};
        foreach (rises[i]) if (tt >= rises[i] && tt < rises[i] + 10) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        bit rq;
        #1 RST_SW_t = 1'b1;
        #2;
        checkVal("reset_pps", PPS_OUT, 1'b0);
        checkVal("reset_sec", SEC_CNT, 32'd0);
        checkVal("reset_busy", BUSY, 1'b0);
        checkVal("reset_pps_rst", PPS_RST_OUT, 1'b0);
        checkVal("reset_ack", RST_ACK, 1'b0);
        checkVal("reset_locked", PPS_LOCKED, 1'b0);
        repeat (2) @(negedge CLK_OUT);
        RST_SW_t = 1'b0;
        model_on = 1'b1;

        repeat (250) applyStimulus(1'b0);
        doRequest(20, 150);
        doRequest(50, 200);
        doRequest(70, 1);
        for (int i = 0; i < 5; i++) doRequest($urandom_range(0, HZ - 1), $urandom_range(1, 220));

        rq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) rq = ~rq;
            applyStimulus(rq);
        end
        drain();

        // Reset in the middle of the pulse must clear everything at once.
        while (((t + 1) % HZ) != 30) applyStimulus(1'b0);
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b1);
            if (act && t == tw + 2) break;
        end
        #1 RST_SW_t = 1'b1;
        #1;
        checkVal("abort_pps_rst", PPS_RST_OUT, 1'b0);
        checkVal("abort_ack", RST_ACK, 1'b0);
        checkVal("abort_busy", BUSY, 1'b0);
        checkVal("abort_sec", SEC_CNT, 32'd0);
        checkVal("abort_pps", PPS_OUT, 1'b0);
        RST_REQ = 1'b0;
        act     = 1'b0;
        clr_q.delete();
        repeat (3) @(negedge CLK_OUT);
        RST_SW_t = 1'b0;
        repeat (250) applyStimulus(1'b0);

`ifdef PPS_EXT_ALIGN_EN
        model_on = 1'b0;
        RST_REQ  = 1'b0;
        PPS_IN   = 1'b0;
        @(negedge CLK_OUT);
        RST_SW_t = 1'b1;
        repeat (2) @(negedge CLK_OUT);
        RST_SW_t = 1'b0;
        while (t < 810) begin
            @(negedge CLK_OUT);
            case (t)
                239: checkVal("ext_lock_pre", PPS_LOCKED, 1'b0);
                241: checkVal("ext_lock_aligned", PPS_LOCKED, 1'b1);
                435: checkVal("ext_lock_one_miss", PPS_LOCKED, 1'b1);
                445: checkVal("ext_lock_two_miss", PPS_LOCKED, 1'b0);
                705: checkVal("ext_realign_hi", PPS_OUT, 1'b1);
                715: checkVal("ext_realign_lo", PPS_OUT, 1'b0);
                750: checkVal("ext_relock", PPS_LOCKED, 1'b1);
                800: begin
                    checkVal("ext_early_unlock", PPS_LOCKED, 1'b0);
                    checkVal("ext_early_realign", PPS_OUT, 1'b1);
                end
                default: ;
            endcase
            PPS_IN = extPulse(t);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
